carry_pipe_adder: RTL and testbench

Pipelined wide adder that registers the carry chain at fixed segment boundaries so a WIDTH-bit add closes timing at high clock rates. Each pipeline stage adds one WIDTH/STAGES-bit segment with 4-bit carry-select blocks, the same slice arithmetic as the combinational carry-select adder. The block sits between the operand source and the sum consumer. A valid/ready handshake is provided on both sides, so it drops into the `pipeline_adder` datapath with backpressure.

---
 rtl/carry_pipe_adder.sv | 111 +++++++++++
 tb/tb_carry_pipe_adder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/carry_pipe_adder.sv
// carry_pipe_adder: pipelined carry-select adder with valid/ready; CARRY_PIPE_ADDER_OVF_EN adds registered signed overflow
module carry_pipe_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef CARRY_PIPE_ADDER_OVF_EN
  ,
  output logic             ovf_o
`endif
);
  localparam int SEG = WIDTH / STAGES;
  localparam int AW  = (STAGES > 1) ? (STAGES - 1) * WIDTH / 2 : 1;
  localparam int SW  = SEG * STAGES * (STAGES + 1) / 2;
  // Operand remainders and partial sums shrink/grow per stage, packed back to back
  function automatic int aoff(input int k);
    return k * WIDTH - SEG * k * (k + 1) / 2;
  endfunction
  function automatic int soff(input int k);
    return SEG * k * (k + 1) / 2;
  endfunction
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x, input logic [SEG-1:0] y, input logic ci);
    logic [SEG-1:0] s;
    logic           c;
    logic [4:0]     r0, r1;
    s = '0;
    c = ci;
    for (int i = 0; i < SEG / 4; i++) begin
      r0 = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]};
      r1 = r0 + 5'd1;
      s[4*i +: 4] = c ? r1[3:0] : r0[3:0];
      c = c ? r1[4] : r0[4];
    end
    return {c, s};
  endfunction
  logic                adv;
  logic [STAGES-1:0]   v_q, v_d, c_q, c_d;
  logic [AW-1:0]       a_q, a_d, b_q, b_d;
  logic [SW-1:0]       s_q, s_d;
`ifdef CARRY_PIPE_ADDER_OVF_EN
  logic                ovf_d, ovf_q;
`endif
  assign adv         = ~v_q[STAGES-1] | out_ready_i;
  assign in_ready_o  = adv;
  assign out_valid_o = v_q[STAGES-1];
  assign sum_o       = s_q[soff(STAGES-1) +: WIDTH];
  assign cout_o      = c_q[STAGES-1];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = WIDTH - k * SEG;
    logic [IW-1:0] ia, ib;
    logic          ci, vi;
    logic [SEG:0]  r;
    if (k == 0) begin : g_head
      assign ia = a_i;
      assign ib = b_i;
      assign ci = cin_i;
      assign vi = in_valid_i;
      assign s_d[0 +: SEG] = r[SEG-1:0];
    end else begin : g_body
      assign ia = a_q[aoff(k-1) +: IW];
      assign ib = b_q[aoff(k-1) +: IW];
      assign ci = c_q[k-1];
      assign vi = v_q[k-1];
      assign s_d[soff(k) +: (k+1)*SEG] = {r[SEG-1:0], s_q[soff(k-1) +: k*SEG]};
    end
    assign r      = seg_add(ia[SEG-1:0], ib[SEG-1:0], ci);
    assign v_d[k] = vi;
    assign c_d[k] = r[SEG];
    if (k < STAGES - 1) begin : g_rem
      assign a_d[aoff(k) +: IW-SEG] = ia[IW-1:SEG];
      assign b_d[aoff(k) +: IW-SEG] = ib[IW-1:SEG];
    end
`ifdef CARRY_PIPE_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      assign ovf_d = ia[SEG-1] ^ ib[SEG-1] ^ r[SEG-1] ^ r[SEG];
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else if (adv) begin
      v_q <= v_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
  end
`ifdef CARRY_PIPE_ADDER_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (adv) ovf_q <= ovf_d;
  end
  assign ovf_o = ovf_q;
`endif
endmodule

// File: tb/tb_carry_pipe_adder.sv
// tb_carry_pipe_adder: random and directed stimulus against an arithmetic reference queue
module tb_carry_pipe_adder;
  localparam int W = 64;
  localparam int S = 4;
  typedef struct packed {
    logic         ovf;
    logic         cout;
    logic [W-1:0] sum;
  } res_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout;
  logic [W-1:0] sum;
`ifdef CARRY_PIPE_ADDER_OVF_EN
  logic         ovf;
`endif
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           run = 0;
  int           since = 0;
  int           pops = 0;
  logic         stall = 1'b0;
  logic [W-1:0] h_sum;
  logic         h_cout, h_ovf;
  res_t         q[$];
  logic         hist[0:4095];
  logic         ovh[0:4095];

  carry_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .a_i(a),
    .b_i(b),
    .cin_i(cin),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .sum_o(sum),
    .cout_o(cout)
`ifdef CARRY_PIPE_ADDER_OVF_EN
    ,
    .ovf_o(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    res_t         m;
    logic [W:0]   u, sx;
    u  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    sx = {x[W-1], x} + {y[W-1], y} + {{W{1'b0}}, c};
    m.sum  = u[W-1:0];
    m.cout = u[W];
    m.ovf  = sx[W] != sx[W-1];
    return m;
  endfunction

  function automatic logic [W-1:0] rnd();
    int sel;
    sel = $urandom_range(0, 7);
    return sel == 0 ? '1 : sel == 1 ? '0 : {$urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    res_t e;
    cyc++;
    if (rst) begin
      q.delete();
      run = 0;
      since = 0;
      stall = 1'b0;
      hist[cyc % 4096] = 1'b0;
    end else begin
      since = since < 5 ? since + 1 : 5;
      if (since <= 4) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
`ifdef CARRY_PIPE_ADDER_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
      end
      if (since == 1) chk("rst_in_ready", in_ready, 1);
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_sum", sum, h_sum);
        chk("stall_cout", cout, h_cout);
`ifdef CARRY_PIPE_ADDER_OVF_EN
        chk("stall_ovf", ovf, h_ovf);
`endif
      end
      if (run >= S) chk("latency_valid", out_valid, hist[(cyc - S) % 4096]);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat cyc=%0d got=%h want=none", cyc, sum);
        end else begin
          e = q.pop_front();
          chk("sum", sum, e.sum);
          chk("cout", cout, e.cout);
`ifdef CARRY_PIPE_ADDER_OVF_EN
          chk("ovf", ovf, e.ovf);
`endif
          pops++;
        end
      end
      hist[cyc % 4096] = in_valid && in_ready;
      if (in_valid && in_ready) q.push_back(model(a, b, cin));
      run = out_ready ? run + 1 : 0;
      stall = out_valid && !out_ready;
      h_sum = sum;
      h_cout = cout;
`ifdef CARRY_PIPE_ADDER_OVF_EN
      h_ovf = ovf;
`else
      h_ovf = 1'b0;
`endif
    end
    ovh[cyc % 4096] = out_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    in_valid = v;
    a = x;
    b = y;
    cin = c;
    step();
  endtask

  task automatic send_wait(input string nm, input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                           input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    out_ready = 1'b1;
    put(1'b1, x, y, c);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk({nm, "_latency"}, n, S);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
`ifdef CARRY_PIPE_ADDER_OVF_EN
    chk({nm, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unexpected ovf flag");
`endif
    step();
  endtask

  initial begin
    int         p0, c0;
    logic [4:0] pat;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    send_wait("lat", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
    send_wait("wrap", '1, '0, 1'b1, '0, 1'b1, 1'b0);
    send_wait("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    p0 = pops;
    for (int i = 0; i < 16; i++) put(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    repeat (S + 1) step();
    chk("thru_count", pops - p0, 16);
    out_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 14; i++) put(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)));
    chk("bp_in_ready", in_ready, 0);
    chk("bp_held", pops - p0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) put(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    repeat (S + 2) step();
    chk("bp_drain", pops - p0, 10);
    chk("bp_queue", q.size(), 0);
    for (int i = 0; i < 300; i++) begin
      out_ready = $urandom_range(0, 3) != 0;
      put($urandom_range(0, 2) != 0, rnd(), rnd(), 1'($urandom_range(0, 1)));
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (S + 2) step();
    chk("rand_queue", q.size(), 0);
    pat = 5'b01101;
    c0 = cyc + 1;
    for (int i = 0; i < 5; i++) put(pat[i], rnd(), rnd(), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 5; i++) chk($sformatf("bubble_%0d", i), ovh[(c0 + S + i) % 4096], pat[i]);
    p0 = pops;
    for (int i = 0; i < 3; i++) put(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)));
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    send_wait("post_rst", 64'h1234, 64'd1, 1'b1, 64'h1236, 1'b0, 1'b0);
    chk("rst_discard", pops - p0, 1);
    repeat (2) step();
    chk("final_queue", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
